// File: rtl/proc9_program_sequencer.sv
// Program sequencer for the 9-bit bus processor: fetches instructions (plus the mvi immediate)
// from a synchronous ROM, drives Run/DataIn, waits for Done and stops at end of program.
module proc9_program_sequencer #(
  parameter int          W       = 9,
  parameter int          ADDR_W  = 8,
  parameter logic [2:0]  OP_MVI  = 3'b001,
  parameter int          TIMEOUT = 8
) (
  input  logic              clock,
  input  logic              aResetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] prog_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [W-1:0]      mem_data,
  output logic              proc_run,
  output logic [W-1:0]      proc_din,
  input  logic              proc_done,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] instr_count
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH_I = 4'd1;
  localparam logic [3:0] S_LATCH_I = 4'd2;
  localparam logic [3:0] S_FETCH_D = 4'd3;
  localparam logic [3:0] S_LATCH_D = 4'd4;
  localparam logic [3:0] S_ISSUE   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_HALT    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  localparam int              WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  logic [3:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_count;
  logic [W-1:0]      r_ir;
  logic [W-1:0]      r_imm;
  logic [WD_W-1:0]   r_wd;

  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_fetch;
  logic              w_ir_mvi;
  logic              w_rom_mvi;

  assign w_pc_inc  = r_pc + 1'b1;
  assign w_fetch   = (r_state == S_FETCH_I) || (r_state == S_FETCH_D);
  assign w_ir_mvi  = (r_ir[W-1 -: 3] == OP_MVI);
  assign w_rom_mvi = (mem_data[W-1 -: 3] == OP_MVI);

  always_ff @(posedge clock) begin
    if (!aResetn) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_ir    <= '0;
      r_imm   <= '0;
      r_wd    <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_HALT, S_ERR: begin
          if (start) begin
            r_len   <= prog_len;
            r_pc    <= '0;
            r_count <= '0;
            r_state <= (prog_len == '0) ? S_HALT : S_FETCH_I;
          end
        end
        S_FETCH_I: r_state <= S_LATCH_I;
        S_LATCH_I: begin
          r_ir <= mem_data;
          r_pc <= w_pc_inc;
          // An mvi in the last program word has no immediate to follow it.
          if (w_rom_mvi) r_state <= (w_pc_inc == r_len) ? S_ERR : S_FETCH_D;
          else           r_state <= S_ISSUE;
        end
        S_FETCH_D: r_state <= S_LATCH_D;
        S_LATCH_D: begin
          r_imm   <= mem_data;
          r_pc    <= w_pc_inc;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_wd <= r_wd + 1'b1;
          if (proc_done) begin
            r_count <= r_count + 1'b1;
            r_state <= (r_pc == r_len) ? S_HALT : S_FETCH_I;
          end else if (r_wd == WD_MAX) begin
            r_state <= S_ERR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decodes only: proc_done never reaches an output combinationally.
  assign mem_rd      = w_fetch;
  assign mem_addr    = w_fetch ? r_pc : '0;
  assign proc_run    = (r_state == S_ISSUE);
  assign proc_din    = (r_state == S_ISSUE) ? r_ir :
                       (r_state == S_EXEC)  ? (w_ir_mvi ? r_imm : r_ir) : '0;
  assign busy        = !((r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERR));
  assign halted      = (r_state == S_HALT);
  assign error       = (r_state == S_ERR);
  assign instr_count = r_count;

endmodule

// File: tb/tb_proc9_program_sequencer.sv
// Bench: ROM + processor stand-in around the sequencer, per-cycle trace model, literal pins.
module tb_proc9_program_sequencer;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic       run;
    logic [8:0] din;
    logic       busy;
    logic       halted;
    logic       error;
    logic [7:0] cnt;
  } obs_t;

  logic       clock = 1'b0;
  logic       aResetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] prog_len = '0;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [8:0] mem_data;
  logic       proc_run;
  logic [8:0] proc_din;
  logic       proc_done;
  logic       busy, halted, error;
  logic [7:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  proc9_program_sequencer #(.W(9), .ADDR_W(8), .OP_MVI(3'b001), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .aResetn(aResetn), .start(start), .abort(abort), .prog_len(prog_len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .proc_run(proc_run), .proc_din(proc_din), .proc_done(proc_done),
    .busy(busy), .halted(halted), .error(error), .instr_count(instr_count)
  );

  // Synchronous program ROM: data one cycle after the read strobe.
  logic [8:0] rom [256];
  always @(posedge clock) if (mem_rd) mem_data <= rom[mem_addr];

  // Processor stand-in: mv/mvi finish in T1, add/sub in T3; Done is combinational.
  logic       done_tie0 = 1'b0;
  logic [1:0] pst;
  logic [8:0] pir, pa, pg;
  logic [8:0] preg [8];
  wire  [2:0] pop = pir[8:6];
  wire  [2:0] px  = pir[5:3];
  wire  [2:0] py  = pir[2:0];
  assign proc_done = !done_tie0 && ((pst == 2'd1 && pop[2:1] == 2'b00) || pst == 2'd3);

  always @(posedge clock) begin
    if (!aResetn) begin
      pst <= 2'd0; pir <= '0; pa <= '0; pg <= '0;
      for (int i = 0; i < 8; i++) preg[i] <= '0;
    end else begin
      case (pst)
        2'd0: if (proc_run) begin pir <= proc_din; pst <= 2'd1; end
        2'd1: begin
          if (pop[2:1] == 2'b00) begin
            if (proc_done) begin
              preg[px] <= pop[0] ? proc_din : preg[py];
              pst <= 2'd0;
            end
          end else begin
            pa <= preg[px]; pst <= 2'd2;
          end
        end
        2'd2: begin pg <= pop[0] ? pa - preg[py] : pa + preg[py]; pst <= 2'd3; end
        default: if (proc_done) begin preg[px] <= pg; pst <= 2'd0; end
      endcase
    end
  end

  // Expected observation per cycle; steady holds once the queue drains.
  obs_t exp_q[$];
  obs_t steady = '0;
  obs_t cmp_a, cmp_e;
  logic chk_en = 1'b0;

  always @(negedge clock) begin
    if (chk_en) begin
      cmp_a = {mem_rd, mem_addr, proc_run, proc_din, busy, halted, error, instr_count};
      cmp_e = (exp_q.size() > 0) ? exp_q.pop_front() : steady;
      checks++;
      if (cmp_a !== cmp_e) begin
        errors++;
        $display("FAIL cycle_trace t=%0t actual rd=%b addr=%0d run=%b din=%o busy=%b halt=%b err=%b cnt=%0d required rd=%b addr=%0d run=%b din=%o busy=%b halt=%b err=%b cnt=%0d",
                 $time, cmp_a.rd, cmp_a.addr, cmp_a.run, cmp_a.din, cmp_a.busy, cmp_a.halted, cmp_a.error, cmp_a.cnt,
                 cmp_e.rd, cmp_e.addr, cmp_e.run, cmp_e.din, cmp_e.busy, cmp_e.halted, cmp_e.error, cmp_e.cnt);
      end
    end
  end

  // Length of the most recent execute phase, and sticky activity flags.
  int   exec_n = 0, last_exec = 0;
  logic in_exec = 1'b0;
  logic rd_seen = 1'b0, run_seen = 1'b0;
  always @(negedge clock) begin
    if (mem_rd)   rd_seen = 1'b1;
    if (proc_run) begin run_seen = 1'b1; in_exec = 1'b1; exec_n = 0; end
    else if (in_exec) begin
      if (busy && !mem_rd) exec_n++;
      else begin in_exec = 1'b0; last_exec = exec_n; end
    end
  end

  function automatic obs_t mk(bit rd, int addr, bit run, logic [8:0] din, bit b, bit h, bit e, int c);
    obs_t o;
    o.rd = rd; o.addr = addr[7:0]; o.run = run; o.din = din;
    o.busy = b; o.halted = h; o.error = e; o.cnt = c[7:0];
    return o;
  endfunction

  // Expand the program in ROM into the cycle trace the sequencer must show.
  task automatic build(input int len, input bit tied0);
    int pc = 0, cnt = 0, n;
    logic [8:0] ir, imm, din;
    exp_q.delete();
    exp_q.push_back(steady);
    if (len == 0) begin steady = mk(0, 0, 0, 0, 0, 1, 0, 0); return; end
    while (1'b1) begin
      exp_q.push_back(mk(1, pc, 0, 0, 1, 0, 0, cnt));
      ir = rom[pc]; pc++;
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, cnt));
      if (ir[8:6] == 3'b001) begin
        if (pc == len) begin steady = mk(0, 0, 0, 0, 0, 0, 1, cnt); return; end
        exp_q.push_back(mk(1, pc, 0, 0, 1, 0, 0, cnt));
        imm = rom[pc]; pc++;
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, cnt));
        din = imm;
      end else din = ir;
      exp_q.push_back(mk(0, 0, 1, ir, 1, 0, 0, cnt));
      n = tied0 ? TIMEOUT : ((ir[8:7] == 2'b00) ? 1 : 3);
      repeat (n) exp_q.push_back(mk(0, 0, 0, din, 1, 0, 0, cnt));
      if (tied0) begin steady = mk(0, 0, 0, 0, 0, 0, 1, cnt); return; end
      cnt++;
      if (pc == len) begin steady = mk(0, 0, 0, 0, 0, 1, 0, cnt); return; end
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    aResetn = 1'b0;
    tick();
    exp_q.delete(); steady = '0; chk_en = 1'b1;
    tick();
    aResetn = 1'b1;
    rd_seen = 1'b0; run_seen = 1'b0;
  endtask

  task automatic start_prog(input int len, input bit tied0);
    prog_len = len[7:0]; start = 1'b1;
    build(len, tied0);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin tick(); k++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain actual=%0d_pending required=0", name, exp_q.size());
      exp_q.delete();
    end
    tick(); tick();
  endtask

  task automatic load_prog2();
    rom[0] = 9'o100; rom[1] = 9'd5; rom[2] = 9'o010;
  endtask

  task automatic load_prog3();
    rom[0] = 9'o100; rom[1] = 9'd3; rom[2] = 9'o110; rom[3] = 9'd4; rom[4] = 9'o201;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    do_reset();
    tick();

    // Empty program halts at once without touching the ROM.
    start_prog(0, 0);
    wait_drain("len0");
    chk("len0_halted", halted, 1);
    chk("len0_count", instr_count, 0);
    chk("len0_no_rd", rd_seen, 0);

    // mvi R0,5 ; mv R1,R0
    do_reset();
    load_prog2();
    start_prog(3, 0);
    wait_drain("prog2");
    chk("prog2_r0", preg[0], 5);
    chk("prog2_r1", preg[1], 5);
    chk("prog2_count", instr_count, 2);
    chk("prog2_halted", halted, 1);
    chk("prog2_mv_exec", last_exec, 1);

    // abort beats start while halted; count is left alone.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    steady = mk(0, 0, 0, 0, 0, 0, 0, 2);
    tick(); tick();
    chk("abort_halt_idle", {busy, halted, error}, 0);

    // mvi R0,3 ; mvi R1,4 ; add R0,R1 with a stray start mid-run.
    do_reset();
    load_prog3();
    start_prog(5, 0);
    repeat (7) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain("prog3");
    chk("prog3_r0", preg[0], 7);
    chk("prog3_count", instr_count, 3);
    chk("prog3_add_exec", last_exec, 3);

    // Lone mvi with no immediate, then restart from ERR.
    do_reset();
    rom[0] = 9'o100;
    start_prog(1, 0);
    wait_drain("trunc");
    chk("trunc_error", error, 1);
    chk("trunc_no_run", run_seen, 0);
    load_prog2();
    start_prog(3, 0);
    wait_drain("restart");
    chk("restart_r1", preg[1], 5);
    chk("restart_halted", halted, 1);

    // Processor never answers: error after TIMEOUT execute cycles.
    do_reset();
    rom[0] = 9'o010;
    done_tie0 = 1'b1;
    start_prog(1, 1);
    wait_drain("timeout");
    chk("timeout_error", error, 1);
    chk("timeout_exec", last_exec, 8);
    done_tie0 = 1'b0;

    // Reset in the second execute cycle of the add.
    do_reset();
    load_prog3();
    start_prog(5, 0);
    repeat (16) tick();
    aResetn = 1'b0;
    tick();
    aResetn = 1'b1;
    exp_q.delete(); steady = '0;
    tick(); tick();
    chk("rst_exec_count", instr_count, 0);

    // abort during LATCH_D of the first mvi.
    load_prog2();
    start_prog(3, 0);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete(); steady = '0;
    tick(); tick();
    chk("abort_ld_busy", busy, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
